// File: rtl/grouper_pkg.sv
// Shared types and helpers for the serial bit grouper.
// Optional even-parity phase is enabled with GROUPER_PARITY_EN.
package grouper_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam int DEFAULT_GROUP_SIZE = 8;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_bit_grouper_out_reg.sv
// One-entry valid/ready output register for assembled groups.
// Holds data, length and parity flag stable until accepted.
module grouper_out_reg
  import grouper_pkg::*;
#(
  parameter int GROUP_SIZE = DEFAULT_GROUP_SIZE,
  parameter int COUNT_W    = 6
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [GROUP_SIZE-1:0] load_data,
  input  logic [COUNT_W-1:0]    load_len,
  input  logic                  load_par,
  input  logic                  ready,
  output logic                  can_load,
  output logic                  valid,
  output logic [GROUP_SIZE-1:0] data,
  output logic [COUNT_W-1:0]    length,
  output logic                  parity
);

  assign can_load = !valid || ready;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      valid  <= 1'b0;
      data   <= '0;
      length <= '0;
      parity <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      data   <= load_data;
      length <= load_len;
      parity <= load_par;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_bit_grouper.sv
// Serial LSB-first bit collector producing valid/ready groups.
// Optional GROUPER_PARITY_EN adds a trailing even-parity bit per group.
module serial_bit_grouper
  import grouper_pkg::*;
#(
  parameter int GROUP_SIZE = DEFAULT_GROUP_SIZE,
  parameter int COUNT_W    = 6
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  bitValid,
  input  logic                  bitIn,
  output logic                  bitReady,
  input  logic                  flush,
  output logic                  groupValid,
  input  logic                  groupReady,
  output logic [GROUP_SIZE-1:0] groupData,
  output logic [COUNT_W-1:0]    groupLength,
  output logic                  overflow,
  output logic                  parityError
);

  state_t                state, state_n;
  logic [GROUP_SIZE-1:0] collect, collect_n;
  logic [COUNT_W-1:0]    bit_count, count_n;
  logic                  hold_par, hold_par_n;
  logic                  overflow_n;

  logic                  load, load_par, can_load;
  logic [GROUP_SIZE-1:0] load_data;
  logic [COUNT_W-1:0]    load_len;

  logic                  accept, complete;
  logic [GROUP_SIZE-1:0] merged;
  logic [COUNT_W-1:0]    merged_cnt;

  assign bitReady   = (state != HOLD);
  assign accept     = bitValid && bitReady;
  assign merged     = collect
                    | ({{(GROUP_SIZE-1){1'b0}}, bitIn} << bit_count);
  assign merged_cnt = bit_count + COUNT_W'(1);

  always_comb begin
    state_n    = state;
    collect_n  = collect;
    count_n    = bit_count;
    hold_par_n = hold_par;
    overflow_n = overflow || (bitValid && !bitReady);
    complete   = 1'b0;
    load       = 1'b0;
    load_data  = collect;
    load_len   = bit_count;
    load_par   = hold_par;
    unique case (state)
      COLLECT: begin
        if (accept) begin
          collect_n = merged;
          count_n   = merged_cnt;
        end
`ifdef GROUPER_PARITY_EN
        if (accept && merged_cnt == COUNT_W'(GROUP_SIZE))
          state_n = PARITY;
        else if (flush && count_n != '0)
          complete = 1'b1;
`else
        if ((accept && merged_cnt == COUNT_W'(GROUP_SIZE)) ||
            (flush && count_n != '0))
          complete = 1'b1;
`endif
      end
      PARITY: begin
        if (accept) begin
          complete   = 1'b1;
          hold_par_n = (^collect) ^ bitIn;
        end
      end
      HOLD: begin
        if (can_load) begin
          load       = 1'b1;
          collect_n  = '0;
          count_n    = '0;
          hold_par_n = 1'b0;
          state_n    = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
    // Completed group goes straight out if the slot frees, else parks in HOLD.
    if (complete) begin
      if (can_load) begin
        load       = 1'b1;
        load_data  = collect_n;
        load_len   = count_n;
        load_par   = hold_par_n;
        collect_n  = '0;
        count_n    = '0;
        hold_par_n = 1'b0;
        state_n    = COLLECT;
      end else begin
        state_n = HOLD;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state     <= COLLECT;
      collect   <= '0;
      bit_count <= '0;
      hold_par  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      collect   <= collect_n;
      bit_count <= count_n;
      hold_par  <= hold_par_n;
      overflow  <= overflow_n;
    end
  end

  grouper_out_reg #(
    .GROUP_SIZE (GROUP_SIZE),
    .COUNT_W    (COUNT_W)
  ) u_out (
    .clock     (clock),
    .resetN    (resetN),
    .load      (load),
    .load_data (load_data),
    .load_len  (load_len),
    .load_par  (load_par),
    .ready     (groupReady),
    .can_load  (can_load),
    .valid     (groupValid),
    .data      (groupData),
    .length    (groupLength),
    .parity    (parityError)
  );

endmodule

// File: tb/tb_serial_bit_grouper.sv
// Directed self-checking bench for serial_bit_grouper (GROUP_SIZE=8).
// Works with or without GROUPER_PARITY_EN.
module tb_serial_bit_grouper;

  logic       clock = 1'b0;
  logic       resetN;
  logic       bitValid, bitIn, bitReady, flush;
  logic       groupValid, groupReady;
  logic [7:0] groupData;
  logic [5:0] groupLength;
  logic       overflow, parityError;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  serial_bit_grouper #(.GROUP_SIZE(8), .COUNT_W(6)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .bitValid    (bitValid),
    .bitIn       (bitIn),
    .bitReady    (bitReady),
    .flush       (flush),
    .groupValid  (groupValid),
    .groupReady  (groupReady),
    .groupData   (groupData),
    .groupLength (groupLength),
    .overflow    (overflow),
    .parityError (parityError)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bitValid = 1'b1;
      bitIn    = v[i];
      step();
    end
    bitValid = 1'b0;
    bitIn    = 1'b0;
  endtask

  task automatic send_group(input logic [7:0] v);
    send_bits({24'd0, v}, 8);
`ifdef GROUPER_PARITY_EN
    send_bits({31'd0, ^v}, 1);
`endif
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0; bitValid = 1'b0; bitIn = 1'b0;
    flush = 1'b0; groupReady = 1'b1;
    do_reset();
    check("rst_valid", {31'd0, groupValid}, 0);
    check("rst_data", {24'd0, groupData}, 0);
    check("rst_len", {26'd0, groupLength}, 0);
    check("rst_ovf", {31'd0, overflow}, 0);
    check("rst_perr", {31'd0, parityError}, 0);
    check("rst_ready", {31'd0, bitReady}, 1);

    // Basic group 0x4D, 1-cycle latency
    send_bits(32'h4D, 7);
    check("t1_early", {31'd0, groupValid}, 0);
    check("t1_ready", {31'd0, bitReady}, 1);
    send_bits(32'h0, 1);
`ifdef GROUPER_PARITY_EN
    check("t1_par_wait", {31'd0, groupValid}, 0);
    send_bits(32'h0, 1);
`endif
    check("t1_valid", {31'd0, groupValid}, 1);
    check("t1_data", {24'd0, groupData}, 32'h4D);
    check("t1_len", {26'd0, groupLength}, 8);
    check("t1_perr", {31'd0, parityError}, 0);
    step();
    check("t1_drop", {31'd0, groupValid}, 0);

    // Back-pressure: two groups, second parks in HOLD
    groupReady = 1'b0;
    send_group(8'hFF);
    check("t2_first", {24'd0, groupData}, 32'hFF);
    check("t2_rdy_mid", {31'd0, bitReady}, 1);
    send_group(8'h01);
    check("t2_hold", {31'd0, bitReady}, 0);
    check("t2_stable", {24'd0, groupData}, 32'hFF);
    groupReady = 1'b1;
    step();
    check("t2_second_v", {31'd0, groupValid}, 1);
    check("t2_second_d", {24'd0, groupData}, 32'h01);
    check("t2_second_l", {26'd0, groupLength}, 8);
    check("t2_rdy_back", {31'd0, bitReady}, 1);
    step();
    check("t2_empty", {31'd0, groupValid}, 0);
    check("t2_ovf", {31'd0, overflow}, 0);

    // Flush of partial groups
    send_bits(32'h3, 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_valid", {31'd0, groupValid}, 1);
    check("t3_data", {24'd0, groupData}, 32'h03);
    check("t3_len", {26'd0, groupLength}, 3);
    check("t3_perr", {31'd0, parityError}, 0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_empty_flush", {31'd0, groupValid}, 0);
    send_bits(32'h1, 2);
    bitValid = 1'b1; bitIn = 1'b1; flush = 1'b1;
    step();
    bitValid = 1'b0; bitIn = 1'b0; flush = 1'b0;
    check("t3_bf_data", {24'd0, groupData}, 32'h05);
    check("t3_bf_len", {26'd0, groupLength}, 3);
    step();

    // Overflow while held
    groupReady = 1'b0;
    send_group(8'hAA);
    send_group(8'h55);
    check("t4_hold", {31'd0, bitReady}, 0);
    check("t4_ovf0", {31'd0, overflow}, 0);
    bitValid = 1'b1; bitIn = 1'b1;
    step();
    bitValid = 1'b0; bitIn = 1'b0;
    check("t4_ovf1", {31'd0, overflow}, 1);
    groupReady = 1'b1;
    step();
    check("t4_held_d", {24'd0, groupData}, 32'h55);
    step();
    step();
    check("t4_sticky", {31'd0, overflow}, 1);

    // Reset aborts partial group
    send_bits(32'h1F, 5);
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    check("t5_ovf", {31'd0, overflow}, 0);
    check("t5_valid", {31'd0, groupValid}, 0);
    check("t5_data", {24'd0, groupData}, 0);
    check("t5_len", {26'd0, groupLength}, 0);
    check("t5_ready", {31'd0, bitReady}, 1);
    send_group(8'h3C);
    check("t5_fresh_v", {31'd0, groupValid}, 1);
    check("t5_fresh_d", {24'd0, groupData}, 32'h3C);
    check("t5_fresh_l", {26'd0, groupLength}, 8);
    step();

`ifdef GROUPER_PARITY_EN
    send_bits(32'h14D, 9);
    check("t6_perr1", {31'd0, parityError}, 1);
    check("t6_data", {24'd0, groupData}, 32'h4D);
    step();
    send_bits(32'h04D, 9);
    check("t6_perr0", {31'd0, parityError}, 0);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
